tank_shell: RTL and testbench

- Projectile engine at the receiving end of the tank's fire interface.
- Consumes the tank's shoot, position, Direction and y_component outputs; flies one ballistic shell per frame tick over the parabolic terrain.
- Reports a one-frame hit pulse, which feeds the opposing tank's hit input.
- One instance per tank; the top level routes each shell's hit to the enemy tank.

---
 rtl/tank_pkg.sv | 18 +
 rtl/terrain_height.sv | 19 +
 rtl/tank_shell.sv | 138 +++++++++++++
 tb/tb_tank_shell.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared tank/shell definitions: shell FSM states, screen limits, terrain coefficients.
package tank_pkg;
  typedef enum logic [1:0] {IDLE, FLIGHT, COOLDOWN} shell_state_t;

  localparam int SCREEN_X_MAX = 639;
  localparam int SCREEN_Y_MAX = 479;

  // terrain(x) = A_NUM*x^2/A_DEN - B_NUM*x/B_DEN + C
  localparam int TERR_A_NUM = 607;
  localparam int TERR_A_DEN = 1562500;
  localparam int TERR_B_NUM = 71;
  localparam int TERR_B_DEN = 500;
  localparam int TERR_C     = 222;

  function automatic logic signed [12:0] sabs(input logic signed [12:0] v);
    return (v < 0) ? -v : v;
  endfunction
endpackage

// File: rtl/terrain_height.sv
// Combinational parabolic terrain profile, x -> ground y (screen coords, down positive).
module terrain_height
  import tank_pkg::*;
(
  input  logic signed [10:0] x,
  output logic signed [10:0] y
);
  logic signed [31:0] xs;
  logic signed [31:0] h;

  always_comb begin
    xs = {{21{x[10]}}, x};
    // each division truncates independently, matching the renderer's profile
    h  = (TERR_A_NUM * xs * xs) / TERR_A_DEN - (TERR_B_NUM * xs) / TERR_B_DEN + TERR_C;
    if (h > 32'sd1023)       y = 11'sd1023;
    else if (h < -32'sd1024) y = -11'sd1024;
    else                     y = h[10:0];
  end
endmodule

// File: rtl/tank_shell.sv
// Ballistic shell engine: one motion step per frame, hit/ground/off-screen resolution.
// Optional wind input enabled by defining TANK_SHELL_WIND_EN.
module tank_shell
  import tank_pkg::*;
#(
  parameter int X_SPEED         = 2,
  parameter int GRAVITY         = 1,
  parameter int HIT_R           = 4,
  parameter int LAUNCH_OFF      = 8,
  parameter int COOLDOWN_FRAMES = 30,
  parameter int X_MAX           = SCREEN_X_MAX
)(
  input  logic              frame_clk,
  input  logic              Reset,
  input  logic              shoot,
  input  logic [9:0]        ShooterX,
  input  logic [9:0]        ShooterY,
  input  logic [1:0]        Direction,
  input  logic [9:0]        y_component,
  input  logic [9:0]        TargetX,
  input  logic [9:0]        TargetY,
  input  logic [9:0]        TargetS,
`ifdef TANK_SHELL_WIND_EN
  input  logic signed [2:0] wind,
`endif
  output logic [9:0]        ShellX,
  output logic signed [10:0] ShellY,
  output logic              shell_active,
  output logic              hit,
  output logic              busy
);
  localparam int CW = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(COOLDOWN_FRAMES - 1);

  shell_state_t       state, state_d;
  logic signed [10:0] sx, sy, vy, dx;
  logic [CW-1:0]      cnt;
  logic               shoot_q, hit_q;

  logic               fire;
  logic signed [10:0] nx, ny, terr_y, dx_launch, vy_nxt;
  logic signed [11:0] vy_w;
  logic signed [12:0] ddx, ddy, lim;
  logic               in_hit, grounded, off_scr;
  logic               unused_dir;

  assign unused_dir = Direction[1];

  terrain_height u_terrain (.x(nx), .y(terr_y));

  always_comb begin
    fire     = shoot & ~shoot_q;
    nx       = sx + dx;
    ny       = sy + vy;
    vy_w     = {vy[10], vy} + 12'(GRAVITY);
    vy_nxt   = (vy_w > 12'sd255) ? 11'sd255 : vy_w[10:0];
    ddx      = {{2{nx[10]}}, nx} - {3'b000, TargetX};
    ddy      = {{2{ny[10]}}, ny} - {3'b000, TargetY};
    lim      = {3'b000, TargetS} + 13'(HIT_R);
    in_hit   = (sabs(ddx) <= lim) && (sabs(ddy) <= lim);
    grounded = (ny >= terr_y);
    off_scr  = (nx < 11'sd0) || (nx > 11'(X_MAX));
  end

  always_comb begin
    dx_launch = Direction[0] ? 11'(X_SPEED) : -11'(X_SPEED);
`ifdef TANK_SHELL_WIND_EN
    dx_launch = dx_launch + {{8{wind[2]}}, wind};
    // a stalled shell would never resolve; nudge it toward the barrel
    if (dx_launch == 11'sd0) dx_launch = Direction[0] ? 11'sd1 : -11'sd1;
`endif
  end

  // state register
  always_ff @(posedge frame_clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:     if (fire) state_d = FLIGHT;
      FLIGHT:   if (in_hit || grounded || off_scr) state_d = COOLDOWN;
      COOLDOWN: if (cnt == CNT_LAST) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // datapath
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      sx      <= '0;
      sy      <= '0;
      vy      <= '0;
      dx      <= '0;
      cnt     <= '0;
      shoot_q <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      shoot_q <= shoot;
      hit_q   <= 1'b0;
      unique case (state)
        IDLE: if (fire) begin
          sx <= {1'b0, ShooterX};
          sy <= {1'b0, ShooterY} - 11'(LAUNCH_OFF);
          vy <= -{1'b0, y_component};
          dx <= dx_launch;
        end
        FLIGHT: begin
          vy  <= vy_nxt;
          cnt <= '0;
          // on ground/off-screen exit the last airborne position is kept
          if (in_hit) begin
            sx    <= nx;
            sy    <= ny;
            hit_q <= 1'b1;
          end else if (!grounded && !off_scr) begin
            sx <= nx;
            sy <= ny;
          end
        end
        COOLDOWN: cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // outputs
  always_comb begin
    ShellX       = sx[9:0];
    ShellY       = sy;
    shell_active = (state == FLIGHT);
    busy         = (state != IDLE);
    hit          = hit_q;
  end
endmodule

// File: tb/tb_tank_shell.sv
// Self-checking bench for tank_shell: closed-form ballistic model, directed and random shots.
module tb_tank_shell;
  logic              frame_clk = 1'b0;
  logic              Reset, shoot;
  logic [9:0]        ShooterX, ShooterY, y_component, TargetX, TargetY, TargetS;
  logic [1:0]        Direction;
  logic [9:0]        ShellX;
  logic signed [10:0] ShellY;
  logic              shell_active, hit, busy;
`ifdef TANK_SHELL_WIND_EN
  logic signed [2:0] wind = 3'sd0;
`endif

  int total = 0, bad = 0;
  int m_x0, m_y0, m_dx, m_v0;

  tank_shell dut (
    .frame_clk(frame_clk), .Reset(Reset), .shoot(shoot),
    .ShooterX(ShooterX), .ShooterY(ShooterY), .Direction(Direction),
    .y_component(y_component), .TargetX(TargetX), .TargetY(TargetY), .TargetS(TargetS),
`ifdef TANK_SHELL_WIND_EN
    .wind(wind),
`endif
    .ShellX(ShellX), .ShellY(ShellY), .shell_active(shell_active), .hit(hit), .busy(busy)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic tick;
    @(posedge frame_clk);
    #1;
  endtask

  function automatic int terr(int x);
    return (607 * x * x) / 1562500 - (71 * x) / 500 + 222;
  endfunction

  function automatic int iabs(int v);
    return (v < 0) ? -v : v;
  endfunction

  // position after k motion updates: linear in x, constant-acceleration in y
  function automatic int px(int k);
    return m_x0 + k * m_dx;
  endfunction
  function automatic int py(int k);
    return (m_y0 - 8) + k * m_v0 + (k * (k - 1)) / 2;
  endfunction

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 300) begin tick(); n++; end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle: busy=%0b after %0d frames, want 0", tag, busy, n);
    end
  endtask

  task automatic run_shot(input int x0, y0, dir, yc, tx, ty, ts, dxv, input string tag);
    int kend, kind, nx, ny, ex, ey, cd;
    bit hit_seen;
    m_x0 = x0; m_y0 = y0; m_dx = dxv; m_v0 = -yc;
    kend = 0; kind = -1;
    for (int k = 1; k < 1000 && kind < 0; k++) begin
      nx = px(k); ny = py(k);
      if (iabs(nx - tx) <= ts + 4 && iabs(ny - ty) <= ts + 4) kind = 0;
      else if (ny >= terr(nx))                              kind = 1;
      else if (nx < 0 || nx > 639)                          kind = 2;
      if (kind >= 0) kend = k;
    end
    ShooterX = 10'(x0); ShooterY = 10'(y0); Direction = 2'(dir); y_component = 10'(yc);
    TargetX = 10'(tx); TargetY = 10'(ty); TargetS = 10'(ts);
    shoot = 1'b1;
    tick();
    shoot = 1'b0;
    total++;
    if (shell_active !== 1'b1 || ShellX !== 10'(x0) || ShellY !== 11'(y0 - 8)) begin
      bad++;
      $display("FAIL %s_launch: act=%0b x=%0d y=%0d, want act=1 x=%0d y=%0d",
               tag, shell_active, ShellX, ShellY, x0, y0 - 8);
    end
    for (int k = 1; k <= kend; k++) begin
      tick();
      total++;
      if (k < kend) begin
        if (shell_active !== 1'b1 || hit !== 1'b0 || ShellX !== 10'(px(k)) || ShellY !== 11'(py(k))) begin
          bad++;
          $display("FAIL %s_fly%0d: act=%0b hit=%0b x=%0d y=%0d, want act=1 hit=0 x=%0d y=%0d",
                   tag, k, shell_active, hit, ShellX, ShellY, px(k), py(k));
        end
      end else begin
        ex = (kind == 0) ? px(k) : px(k - 1);
        ey = (kind == 0) ? py(k) : py(k - 1);
        if (shell_active !== 1'b0 || busy !== 1'b1 || hit !== (kind == 0) ||
            ShellX !== 10'(ex) || ShellY !== 11'(ey)) begin
          bad++;
          $display("FAIL %s_end: act=%0b busy=%0b hit=%0b x=%0d y=%0d, want act=0 busy=1 hit=%0b x=%0d y=%0d",
                   tag, shell_active, busy, hit, ShellX, ShellY, kind == 0, ex, ey);
        end
      end
    end
    cd = 1; hit_seen = 1'b0;
    while (busy && cd < 100) begin
      tick();
      if (busy) begin cd++; hit_seen |= hit; end
    end
    total++;
    if (cd != 30 || hit_seen || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_cooldown: frames=%0d hit_seen=%0b busy=%0b, want 30 0 0", tag, cd, hit_seen, busy);
    end
  endtask

  task automatic test_reset;
    Reset = 1'b1; shoot = 1'b0;
    ShooterX = '0; ShooterY = '0; Direction = '0; y_component = '0;
    TargetX = '0; TargetY = '0; TargetS = '0;
    tick(); tick();
    total++;
    if (ShellX !== 10'd0 || ShellY !== 11'sd0 || shell_active !== 1'b0 || hit !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset: x=%0d y=%0d act=%0b hit=%0b busy=%0b, want all 0",
               ShellX, ShellY, shell_active, hit, busy);
    end
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_drop;
    run_shot(140, 210, 1, 0, 600, 50, 0, 2, "drop");
  endtask

  task automatic test_hit;
    run_shot(140, 210, 1, 0, 144, 203, 4, 2, "hit");
    run_shot(140, 210, 1, 0, 150, 202, 4, 2, "hit_edge");
    run_shot(140, 210, 1, 0, 151, 194, 4, 2, "near_miss");
  endtask

  task automatic test_offscreen;
    run_shot(4, 100, 0, 0, 600, 50, 0, -2, "offscr");
    run_shot(630, 100, 1, 5, 20, 50, 0, 2, "offscr_r");
  endtask

  task automatic test_hold;
    int rises;
    bit prev;
    ShooterX = 10'd140; ShooterY = 10'd210; Direction = 2'd1; y_component = 10'd0;
    TargetX = 10'd600; TargetY = 10'd50; TargetS = 10'd0;
    shoot = 1'b1;
    tick();
    total++;
    if (shell_active !== 1'b1 || ShellX !== 10'd140) begin
      bad++;
      $display("FAIL hold_launch: act=%0b x=%0d, want 1 140", shell_active, ShellX);
    end
    tick();
    shoot = 1'b0;
    tick();
    shoot = 1'b1;
    tick();
    total++;
    if (shell_active !== 1'b1 || ShellX !== 10'd146 || ShellY !== 11'sd205) begin
      bad++;
      $display("FAIL hold_rerise: act=%0b x=%0d y=%0d, want 1 146 205", shell_active, ShellX, ShellY);
    end
    rises = 0; prev = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (shell_active && !prev) rises++;
      prev = shell_active;
    end
    total++;
    if (rises != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL hold_single: extra_launches=%0d busy=%0b, want 0 0", rises, busy);
    end
    shoot = 1'b0;
    tick();
    shoot = 1'b1;
    tick();
    shoot = 1'b0;
    total++;
    if (shell_active !== 1'b1 || ShellX !== 10'd140 || ShellY !== 11'sd202) begin
      bad++;
      $display("FAIL hold_relaunch: act=%0b x=%0d y=%0d, want 1 140 202", shell_active, ShellX, ShellY);
    end
    wait_idle("hold");
  endtask

  task automatic test_reset_flight;
    bit hit_seen, busy_seen, nz;
    ShooterX = 10'd300; ShooterY = 10'd150; Direction = 2'd1; y_component = 10'd10;
    TargetX = 10'd340; TargetY = 10'd150; TargetS = 10'd6;
    shoot = 1'b1; tick(); shoot = 1'b0;
    tick(); tick();
    Reset = 1'b1;
    nz = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ShellX !== 10'd0 || ShellY !== 11'sd0 || shell_active || hit || busy) nz = 1'b1;
    end
    total++;
    if (nz) begin
      bad++;
      $display("FAIL rst_flight: x=%0d y=%0d act=%0b hit=%0b busy=%0b, want all 0 during reset",
               ShellX, ShellY, shell_active, hit, busy);
    end
    Reset = 1'b0;
    hit_seen = 1'b0; busy_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      hit_seen |= hit; busy_seen |= busy;
    end
    total++;
    if (hit_seen || busy_seen) begin
      bad++;
      $display("FAIL rst_release: hit_seen=%0b busy_seen=%0b, want 0 0", hit_seen, busy_seen);
    end
  endtask

  task automatic test_random;
    int x0, y0, dir, yc, dxv, tx, ty, ts;
    for (int n = 0; n < 10; n++) begin
      x0  = $urandom_range(30, 610);
      y0  = $urandom_range(60, 200);
      dir = $urandom_range(0, 1);
      yc  = $urandom_range(0, 30);
      dxv = dir ? 2 : -2;
      ts  = $urandom_range(0, 10);
      if ($urandom_range(0, 1)) begin
        tx = x0 + dxv * $urandom_range(1, 12);
        ty = y0 - $urandom_range(0, 40);
      end else begin
        tx = $urandom_range(0, 639);
        ty = $urandom_range(0, 300);
      end
      if (tx < 0) tx = 0;
      if (tx > 639) tx = 639;
      run_shot(x0, y0, dir, yc, tx, ty, ts, dxv, $sformatf("rnd%0d", n));
    end
  endtask

`ifdef TANK_SHELL_WIND_EN
  task automatic test_wind;
    wind = -3'sd2;
    run_shot(140, 210, 1, 0, 600, 50, 0, 1, "wind_stall");
    wind = 3'sd3;
    run_shot(300, 150, 0, 8, 20, 50, 0, 1, "wind_push");
    wind = 3'sd0;
  endtask
`endif

  initial begin
    test_reset();
    test_drop();
    test_hit();
    test_offscreen();
    test_hold();
    test_reset_flight();
    test_random();
`ifdef TANK_SHELL_WIND_EN
    test_wind();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
